// File: rtl/pc_seq_ctrl.sv
// PC sequencing and IF/ID, ID/EX hazard control with an IDLE/RUN/HALT run-state FSM.
// Optional performance counters are enabled by defining PC_SEQ_CTRL_PERF_EN.
module pc_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        halt_i,
  input  logic [31:0] pc_i,
  input  logic [4:0]  ifid_rs_i,
  input  logic [4:0]  ifid_rt_i,
  input  logic        idex_memread_i,
  input  logic [4:0]  idex_rt_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  output logic [31:0] pc_next_o,
  output logic        pc_we_o,
  output logic        ifid_we_o,
  output logic        ifid_flush_o,
  output logic        idex_bubble_o,
  output logic [1:0]  state_o
`ifdef PC_SEQ_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   hazard;
  logic   redirect;

  // Sequential fetch address; plain 32-bit add wraps FFFF_FFFC to 0.
  function automatic logic [31:0] pc_incr(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // A load targeting r0 never produces a value worth waiting for.
  assign hazard   = idex_memread_i && (idex_rt_i != 5'd0) &&
                    ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));
  assign redirect = jump_i || branch_taken_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_i) state_d = RUN;
      RUN: begin
        if (halt_i && !hazard) state_d = HALT;
        else if (!start_i)     state_d = IDLE;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_next_o     = RESET_PC;
    pc_we_o       = 1'b0;
    ifid_we_o     = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    case (state_q)
      RUN: begin
        if (hazard) begin
          pc_next_o     = pc_i;
          idex_bubble_o = 1'b1;
        end else if (jump_i) begin
          pc_next_o    = jump_target_i;
          pc_we_o      = 1'b1;
          ifid_we_o    = 1'b1;
          ifid_flush_o = 1'b1;
        end else if (branch_taken_i) begin
          pc_next_o    = branch_target_i;
          pc_we_o      = 1'b1;
          ifid_we_o    = 1'b1;
          ifid_flush_o = 1'b1;
        end else begin
          pc_next_o = pc_incr(pc_i);
          pc_we_o   = 1'b1;
          ifid_we_o = 1'b1;
        end
      end
      HALT:    pc_next_o = pc_i;
      default: pc_next_o = RESET_PC;
    endcase
  end

  assign state_o = state_q;

`ifdef PC_SEQ_CTRL_PERF_EN
  logic [31:0] cycle_cnt_q, stall_cnt_q, flush_cnt_q;

  // Counters advance only while running; a stalled redirect is not a flush.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cycle_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else if (state_q == RUN) begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (hazard)        stall_cnt_q <= stall_cnt_q + 32'd1;
      else if (redirect) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign cycle_cnt_o = cycle_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  logic unused_redirect;
  assign unused_redirect = redirect;
`endif

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed bench for pc_seq_ctrl: vector table for RUN decode plus FSM/reset sequences.
module tb_pc_seq_ctrl;
  logic        clk_i = 1'b0;
  logic        rst_i, start_i, halt_i;
  logic [31:0] pc_i;
  logic [4:0]  ifid_rs_i, ifid_rt_i, idex_rt_i;
  logic        idex_memread_i, branch_taken_i, jump_i;
  logic [31:0] branch_target_i, jump_target_i;
  logic [31:0] pc_next_o;
  logic        pc_we_o, ifid_we_o, ifid_flush_o, idex_bubble_o;
  logic [1:0]  state_o;
`ifdef PC_SEQ_CTRL_PERF_EN
  logic [31:0] cycle_cnt_o, stall_cnt_o, flush_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  pc_seq_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .halt_i(halt_i), .pc_i(pc_i),
    .ifid_rs_i(ifid_rs_i), .ifid_rt_i(ifid_rt_i), .idex_memread_i(idex_memread_i),
    .idex_rt_i(idex_rt_i), .branch_taken_i(branch_taken_i),
    .branch_target_i(branch_target_i), .jump_i(jump_i), .jump_target_i(jump_target_i),
    .pc_next_o(pc_next_o), .pc_we_o(pc_we_o), .ifid_we_o(ifid_we_o),
    .ifid_flush_o(ifid_flush_o), .idex_bubble_o(idex_bubble_o), .state_o(state_o)
`ifdef PC_SEQ_CTRL_PERF_EN
    , .cycle_cnt_o(cycle_cnt_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rs, rt, xrt;
    logic        mrd, br;
    logic [31:0] bt;
    logic        jmp;
    logic [31:0] jt;
    logic [31:0] e_next;
    logic        e_pcwe, e_ifwe, e_flush, e_bub;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    halt_i = 0; pc_i = 32'h1234; ifid_rs_i = 0; ifid_rt_i = 0; idex_rt_i = 0;
    idex_memread_i = 0; branch_taken_i = 0; jump_i = 0;
    branch_target_i = 32'h80; jump_target_i = 32'h40;
  endtask

  task automatic check_quiet(input string tag, input logic [31:0] exp_next, input logic [1:0] exp_st);
    check({tag, " state"}, {30'd0, state_o}, {30'd0, exp_st});
    check({tag, " pc_we"}, {31'd0, pc_we_o}, 32'd0);
    check({tag, " ifid_we"}, {31'd0, ifid_we_o}, 32'd0);
    check({tag, " pc_next"}, pc_next_o, exp_next);
  endtask

  initial begin
    tbl[0] = '{32'h10,       0, 0, 0, 0, 0, 32'h80, 0, 32'h40, 32'h14,  1, 1, 0, 0};
    tbl[1] = '{32'hFFFFFFFC, 0, 0, 0, 0, 0, 32'h80, 0, 32'h40, 32'h0,   1, 1, 0, 0};
    tbl[2] = '{32'h100,      1, 8, 8, 1, 1, 32'h80, 0, 32'h40, 32'h100, 0, 0, 0, 1};
    tbl[3] = '{32'h100,      1, 8, 0, 1, 1, 32'h80, 0, 32'h40, 32'h80,  1, 1, 1, 0};
    tbl[4] = '{32'h100,      0, 0, 0, 0, 1, 32'h80, 1, 32'h40, 32'h40,  1, 1, 1, 0};
    tbl[5] = '{32'h200,      0, 0, 0, 0, 1, 32'h80, 0, 32'h40, 32'h80,  1, 1, 1, 0};
    tbl[6] = '{32'h300,      9, 2, 9, 1, 0, 32'h80, 1, 32'h40, 32'h300, 0, 0, 0, 1};
    tbl[7] = '{32'h300,      9, 2, 9, 0, 0, 32'h80, 0, 32'h40, 32'h304, 1, 1, 0, 0};
    tbl[8] = '{32'h400,      3, 4, 5, 1, 0, 32'h80, 0, 32'h40, 32'h404, 1, 1, 0, 0};

    rst_i = 0; start_i = 0; idle_inputs();
    #1 check_quiet("reset", 32'h0, 2'd0);
    @(negedge clk_i); rst_i = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check_quiet("idle_hold", 32'h0, 2'd0);
    end

    // start: first RUN cycle after the next edge
    pc_i = 32'h10; start_i = 1;
    #1 check("pre_start state", {30'd0, state_o}, 32'd0);
    @(negedge clk_i);
    check("run state", {30'd0, state_o}, 32'd1);
    check("run pc_next", pc_next_o, 32'h14);
    check("run pc_we", {31'd0, pc_we_o}, 32'd1);

    for (int i = 0; i < 9; i++) begin
      @(negedge clk_i);
      pc_i = tbl[i].pc; ifid_rs_i = tbl[i].rs; ifid_rt_i = tbl[i].rt;
      idex_rt_i = tbl[i].xrt; idex_memread_i = tbl[i].mrd; branch_taken_i = tbl[i].br;
      branch_target_i = tbl[i].bt; jump_i = tbl[i].jmp; jump_target_i = tbl[i].jt;
      #1;
      check($sformatf("vec%0d state", i), {30'd0, state_o}, 32'd1);
      check($sformatf("vec%0d pc_next", i), pc_next_o, tbl[i].e_next);
      check($sformatf("vec%0d pc_we", i), {31'd0, pc_we_o}, {31'd0, tbl[i].e_pcwe});
      check($sformatf("vec%0d ifid_we", i), {31'd0, ifid_we_o}, {31'd0, tbl[i].e_ifwe});
      check($sformatf("vec%0d flush", i), {31'd0, ifid_flush_o}, {31'd0, tbl[i].e_flush});
      check($sformatf("vec%0d bubble", i), {31'd0, idex_bubble_o}, {31'd0, tbl[i].e_bub});
    end

    // pause: falling cycle still RUN, IDLE after the edge
    @(negedge clk_i); idle_inputs(); pc_i = 32'h50; start_i = 0;
    #1 check("pause_cycle pc_we", {31'd0, pc_we_o}, 32'd1);
    check("pause_cycle pc_next", pc_next_o, 32'h54);
    @(negedge clk_i);
    check_quiet("paused", 32'h0, 2'd0);
    start_i = 1;
    @(negedge clk_i);
    check("resume state", {30'd0, state_o}, 32'd1);

    // halt during a hazard is ignored
    halt_i = 1; idex_memread_i = 1; idex_rt_i = 7; ifid_rs_i = 7;
    #1 check("halt_hz bubble", {31'd0, idex_bubble_o}, 32'd1);
    @(negedge clk_i);
    check("halt_hz state", {30'd0, state_o}, 32'd1);
    // halt accepted with start low: halt wins, RUN outputs this cycle
    idex_memread_i = 0; start_i = 0; pc_i = 32'h60;
    #1 check("halt_acc pc_we", {31'd0, pc_we_o}, 32'd1);
    check("halt_acc pc_next", pc_next_o, 32'h64);
    @(negedge clk_i);
    halt_i = 0; pc_i = 32'h64;
    #1 check_quiet("halted", 32'h64, 2'd2);
    check("halted flush", {31'd0, ifid_flush_o}, 32'd0);
    check("halted bubble", {31'd0, idex_bubble_o}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i); start_i = ~start_i; jump_i = 1;
      #1 check("halt_sticky state", {30'd0, state_o}, 32'd2);
    end

    // asynchronous reset mid-cycle
    #2 rst_i = 0;
    #1 check_quiet("async_rst", 32'h0, 2'd0);
    @(negedge clk_i); rst_i = 1; start_i = 0; idle_inputs();
    @(negedge clk_i);
    check("post_rst state", {30'd0, state_o}, 32'd0);

`ifdef PC_SEQ_CTRL_PERF_EN
    rst_i = 0; #1 rst_i = 1;
    check("perf_rst cycles", cycle_cnt_o, 32'd0);
    start_i = 1;
    @(posedge clk_i);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      idex_memread_i = (i == 2 || i == 5); idex_rt_i = 8; ifid_rt_i = 8;
      jump_i = (i == 7); start_i = (i != 9);
      @(posedge clk_i);
    end
    @(negedge clk_i); idle_inputs();
    check("perf cycles", cycle_cnt_o, 32'd10);
    check("perf stalls", stall_cnt_o, 32'd2);
    check("perf flushes", flush_cnt_o, 32'd1);
    check("perf state", {30'd0, state_o}, 32'd0);
    repeat (3) @(negedge clk_i);
    check("perf hold cycles", cycle_cnt_o, 32'd10);
    check("perf hold stalls", stall_cnt_o, 32'd2);
    check("perf hold flushes", flush_cnt_o, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
